// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - write-back FIFO with load/ALU arbitration and read bypass
// Load has fixed priority; queued entries are forwarded to the read ports until written.
module rf_writeback_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [ADDR_W-1:0]       ld_reg,
  input  logic [DATA_W-1:0]       ld_data,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_reg,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    wb_stall,
  output logic                    regWrite,
  output logic [ADDR_W-1:0]       writeReg,
  output logic [DATA_W-1:0]       writeData,
  input  logic [ADDR_W-1:0]       rd_addr1,
  input  logic [ADDR_W-1:0]       rd_addr2,
  input  logic [DATA_W-1:0]       rf_data1,
  input  logic [DATA_W-1:0]       rf_data2,
  output logic [DATA_W-1:0]       fwd_data1,
  output logic [DATA_W-1:0]       fwd_data2,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_q_reg  [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_ld_fire;
  logic              w_alu_fire;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_in_reg;
  logic [DATA_W-1:0] w_in_data;
  logic [PTR_W-1:0]  w_idx;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign ld_ready   = reset && !w_full;
  assign alu_ready  = reset && !w_full && !ld_valid;
  assign w_ld_fire  = ld_valid && ld_ready;
  assign w_alu_fire = alu_valid && alu_ready;
  assign w_push     = w_ld_fire || w_alu_fire;
  assign w_in_reg   = w_ld_fire ? ld_reg  : alu_reg;
  assign w_in_data  = w_ld_fire ? ld_data : alu_data;

  assign regWrite  = !w_empty && !wb_stall;
  assign w_pop     = regWrite;
  assign writeReg  = w_empty ? '0 : r_q_reg[r_rd_ptr];
  assign writeData = w_empty ? '0 : r_q_data[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_reg[r_wr_ptr]  <= w_in_reg;
      r_q_data[r_wr_ptr] <= w_in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Walk from head to tail so later (younger) matches override older ones.
  always_comb begin
    fwd_data1 = rf_data1;
    fwd_data2 = rf_data2;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if (r_q_reg[w_idx] == rd_addr1) fwd_data1 = r_q_data[w_idx];
        if (r_q_reg[w_idx] == rd_addr2) fwd_data2 = r_q_data[w_idx];
      end
    end
  end
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - directed self-checking bench for rf_writeback_ctrl
module tb_rf_writeback_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_ready, alu_valid, alu_ready, wb_stall, regWrite;
  logic [1:0]  ld_reg, alu_reg, writeReg, rd_addr1, rd_addr2;
  logic [31:0] ld_data, alu_data, writeData, rf_data1, rf_data2, fwd_data1, fwd_data2;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] q_log[$];
  logic [33:0] q_exp[$];

  rf_writeback_ctrl #(.DATA_W(32), .ADDR_W(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .wb_stall(wb_stall), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
  );

  always #5 clk = ~clk;

  // Inputs only change 1ns after a rising edge, so negedge sees the value written at the next edge.
  always @(negedge clk) begin
    if (regWrite) q_log.push_back({writeReg, writeData});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ld_valid = 0; alu_valid = 0; wb_stall = 0;
    ld_reg = 0; ld_data = 0; alu_reg = 0; alu_data = 0;
    rd_addr1 = 0; rd_addr2 = 0; rf_data1 = 0; rf_data2 = 0;
    #3;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_tests++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regWrite: got %b expected 0", regWrite); end
    n_tests++; if (ld_ready !== 1'b0 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got ld=%b alu=%b expected 0/0", ld_ready, alu_ready); end
    n_tests++; if (writeReg !== 2'd0 || writeData !== 32'd0) begin n_fail++; $display("FAIL reset_head: got %0d/%h expected 0/0", writeReg, writeData); end
    step(); step();
    reset = 1'b1;
    #1;
    n_tests++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got ld=%b alu=%b expected 1/1", ld_ready, alu_ready); end
  endtask

  task automatic test_single();
    q_log.delete();
    step();
    ld_valid = 1; ld_reg = 2; ld_data = 32'hDEADBEEF;
    #1;
    n_tests++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL single_pre: got regWrite=%b expected 0", regWrite); end
    step();
    ld_valid = 0;
    #1;
    n_tests++; if (regWrite !== 1'b1 || writeReg !== 2'd2 || writeData !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL single_write: got %b/%0d/%h expected 1/2/deadbeef", regWrite, writeReg, writeData); end
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", count); end
    step();
    n_tests++; if (count !== 3'd0 || regWrite !== 1'b0) begin n_fail++; $display("FAIL single_drained: got count=%0d regWrite=%b expected 0/0", count, regWrite); end
    n_tests++; if (q_log.size() != 1) begin n_fail++; $display("FAIL single_log_size: got %0d expected 1", q_log.size()); end
  endtask

  task automatic test_priority();
    q_log.delete();
    step();
    ld_valid = 1; ld_reg = 1; ld_data = 32'h11;
    alu_valid = 1; alu_reg = 3; alu_data = 32'h33;
    #1;
    n_tests++; if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready: got ld=%b alu=%b expected 1/0", ld_ready, alu_ready); end
    step();
    ld_valid = 0;
    #1;
    n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL prio_alu_next: got %b expected 1", alu_ready); end
    step();
    alu_valid = 0;
    repeat (3) step();
    q_exp = '{{2'd1, 32'h11}, {2'd3, 32'h33}};
    n_tests++; if (q_log.size() != 2) begin n_fail++; $display("FAIL prio_log_size: got %0d expected 2", q_log.size()); end
    for (int i = 0; i < 2 && i < q_log.size(); i++) begin
      n_tests++; if (q_log[i] !== q_exp[i]) begin n_fail++; $display("FAIL prio_order[%0d]: got %h expected %h", i, q_log[i], q_exp[i]); end
    end
  endtask

  task automatic test_stall_full();
    q_log.delete();
    step();
    wb_stall = 1; alu_valid = 1; alu_reg = 0;
    for (int i = 0; i < 5; i++) begin
      alu_data = 32'hA0 + i;
      #1;
      if (i < 4) begin
        n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 1", i, alu_ready); end
        step();
      end else begin
        n_tests++; if (alu_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL stall_full: got ready=%b count=%0d expected 0/4", alu_ready, count); end
      end
    end
    rd_addr1 = 0; rf_data1 = 32'h12345678;
    #1;
    n_tests++; if (fwd_data1 !== 32'hA3) begin n_fail++; $display("FAIL stall_fwd_youngest: got %h expected a3", fwd_data1); end
    n_tests++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL stall_nowrite: got %b expected 0", regWrite); end
    wb_stall = 0;
    #1;
    n_tests++; if (regWrite !== 1'b1 || writeData !== 32'hA0 || alu_ready !== 1'b0)
      begin n_fail++; $display("FAIL stall_release: got %b/%h ready=%b expected 1/a0/0", regWrite, writeData, alu_ready); end
    step();
    n_tests++; if (alu_ready !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL stall_reopen: got ready=%b count=%0d expected 1/3", alu_ready, count); end
    step();
    alu_valid = 0;
    repeat (6) step();
    n_tests++; if (q_log.size() != 5) begin n_fail++; $display("FAIL stall_log_size: got %0d expected 5", q_log.size()); end
    for (int i = 0; i < 5 && i < q_log.size(); i++) begin
      n_tests++; if (q_log[i] !== {2'd0, 32'hA0 + 32'(i)}) begin n_fail++; $display("FAIL stall_order[%0d]: got %h expected %h", i, q_log[i], {2'd0, 32'hA0 + 32'(i)}); end
    end
  endtask

  task automatic test_forward();
    step();
    wb_stall = 1; ld_valid = 1; ld_reg = 2; ld_data = 32'h5;
    rd_addr2 = 2; rf_data2 = 32'h9; rd_addr1 = 2; rf_data1 = 32'h77;
    #1;
    n_tests++; if (fwd_data2 !== 32'h9) begin n_fail++; $display("FAIL fwd_not_yet_visible: got %h expected 9", fwd_data2); end
    step();
    ld_valid = 0;
    #1;
    n_tests++; if (fwd_data2 !== 32'h5 || fwd_data1 !== 32'h5) begin n_fail++; $display("FAIL fwd_hit: got %h/%h expected 5/5", fwd_data1, fwd_data2); end
    rd_addr2 = 1;
    #1;
    n_tests++; if (fwd_data2 !== 32'h9) begin n_fail++; $display("FAIL fwd_miss: got %h expected 9", fwd_data2); end
    rd_addr2 = 2; wb_stall = 0;
    #1;
    n_tests++; if (regWrite !== 1'b1 || fwd_data2 !== 32'h5) begin n_fail++; $display("FAIL fwd_head_writing: got regWrite=%b fwd=%h expected 1/5", regWrite, fwd_data2); end
    step();
    n_tests++; if (fwd_data2 !== 32'h9) begin n_fail++; $display("FAIL fwd_after_drain: got %h expected 9", fwd_data2); end
  endtask

  task automatic test_reset_midflight();
    step();
    wb_stall = 1; ld_valid = 1; ld_reg = 1;
    for (int i = 0; i < 3; i++) begin
      ld_data = 32'h100 + i;
      step();
    end
    ld_valid = 0;
    wb_stall = 0;
    #1;
    n_tests++; if (regWrite !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL midreset_pre: got regWrite=%b count=%0d expected 1/3", regWrite, count); end
    #1 reset = 1'b0;
    #1;
    n_tests++; if (regWrite !== 1'b0 || count !== 3'd0 || ld_ready !== 1'b0)
      begin n_fail++; $display("FAIL midreset_async: got regWrite=%b count=%0d ld_ready=%b expected 0/0/0", regWrite, count, ld_ready); end
    q_log.delete();
    #1 reset = 1'b1;
    repeat (4) step();
    n_tests++; if (q_log.size() != 0 || count !== 3'd0) begin n_fail++; $display("FAIL midreset_stale: got writes=%0d count=%0d expected 0/0", q_log.size(), count); end
  endtask

  task automatic test_back_to_back();
    q_log.delete();
    q_exp.delete();
    step();
    wb_stall = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        ld_valid = 1; alu_valid = 0; ld_reg = 2'(i); ld_data = 32'h1000 + i;
      end else begin
        ld_valid = 0; alu_valid = 1; alu_reg = 2'(i); alu_data = 32'h2000 + i;
      end
      q_exp.push_back({2'(i), (i % 2 == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i)});
      #1;
      n_tests++; if ((ld_valid && !ld_ready) || (alu_valid && !alu_ready))
        begin n_fail++; $display("FAIL b2b_ready[%0d]: got ld=%b alu=%b expected accepted", i, ld_ready, alu_ready); end
      step();
    end
    ld_valid = 0; alu_valid = 0;
    repeat (3) step();
    n_tests++; if (q_log.size() != 12 || count !== 3'd0) begin n_fail++; $display("FAIL b2b_log_size: got %0d count=%0d expected 12/0", q_log.size(), count); end
    for (int i = 0; i < 12 && i < q_log.size(); i++) begin
      n_tests++; if (q_log[i] !== q_exp[i]) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, q_log[i], q_exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_stall_full();
    test_forward();
    test_reset_midflight();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
